// File: rtl/imem_resp_if.sv
// Fetch and loader signal bundle between a PC fetch unit (master) and the
// instruction-memory responder (slave).
interface imem_resp_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              Req;
    logic [29:0]       Addr;
    logic              Ack;
    logic [31:0]       Instr;
    logic              Fault;
    logic              Busy;
    logic              Ld_we;
    logic [ADDR_W-1:0] Ld_addr;
    logic [31:0]       Ld_data;

    modport master (
        output Req, Addr, Ld_we, Ld_addr, Ld_data,
        input  Ack, Instr, Fault, Busy
    );

    modport slave (
        input  Req, Addr, Ld_we, Ld_addr, Ld_data,
        output Ack, Instr, Fault, Busy
    );
endinterface

// File: rtl/imem_resp.sv
// Instruction-memory responder: accepts a word address, returns the stored
// instruction after WAIT wait states, faults on addresses beyond the array.
module imem_resp #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WAIT   = 2
) (
    input  logic         Clk,
    input  logic         Reset_n,
    imem_resp_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [29:0]       addr_q;
    logic              ack;
    logic [31:0]       instr;
    logic              fault;
    logic              busy;

    logic [31:0]       mem [DEPTH];

    logic              accept_c;
    logic              enter_resp_c;
    logic [29:0]       rd_addr_c;
    logic              oor_c;

    // Acceptance happens in IDLE or on the closing edge of RESP; with no wait
    // states the read uses the address presented at that same edge.
    always_comb begin
        accept_c     = 1'b0;
        enter_resp_c = 1'b0;
        rd_addr_c    = addr_q;
        if (state != ST_WAIT) begin
            accept_c = bus.Req;
        end
        if (state == ST_WAIT) begin
            enter_resp_c = (cnt == '0);
        end else if (accept_c && (WAIT == 0)) begin
            enter_resp_c = 1'b1;
            rd_addr_c    = bus.Addr;
        end
        oor_c = |(rd_addr_c >> ADDR_W);
    end

    // Loader port; array contents are deliberately untouched by reset.
    always_ff @(posedge Clk) begin
        if (bus.Ld_we) begin
            mem[bus.Ld_addr] <= bus.Ld_data;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            ack    <= 1'b0;
            instr  <= 32'h0;
            fault  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            ack  <= enter_resp_c;
            busy <= 1'b0;

            if (accept_c) begin
                addr_q <= bus.Addr;
                if (WAIT == 0) begin
                    state <= ST_RESP;
                end else begin
                    state <= ST_WAIT;
                    cnt   <= CNT_INIT;
                    busy  <= 1'b1;
                end
            end else if (state == ST_WAIT) begin
                if (cnt == '0) begin
                    state <= ST_RESP;
                end else begin
                    cnt  <= cnt - CNT_W'(1);
                    busy <= 1'b1;
                end
            end else begin
                state <= ST_IDLE;
            end

            // Registered read: a same-edge loader write is not yet visible.
            if (enter_resp_c) begin
                fault <= oor_c;
                instr <= oor_c ? 32'h0 : mem[rd_addr_c[ADDR_W-1:0]];
            end
        end
    end

    assign bus.Ack   = ack;
    assign bus.Instr = instr;
    assign bus.Fault = fault;
    assign bus.Busy  = busy;

endmodule

// File: tb/tb_imem_resp.sv
// Directed self-checking bench for imem_resp with WAIT=2 and WAIT=0 instances.
module tb_imem_resp;
    logic Clk;
    logic Reset_n;
    int   checks;
    int   passes;

    logic [31:0] words [4] = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};

    imem_resp_if #(.ADDR_W(10)) bus2 ();
    imem_resp_if #(.ADDR_W(10)) bus0 ();

    imem_resp #(.ADDR_W(10), .WAIT(2)) dut  (.Clk(Clk), .Reset_n(Reset_n), .bus(bus2));
    imem_resp #(.ADDR_W(10), .WAIT(0)) dut0 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus0));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        bus2.Ld_we = 1'b1; bus2.Ld_addr = a; bus2.Ld_data = d;
        bus0.Ld_we = 1'b1; bus0.Ld_addr = a; bus0.Ld_data = d;
        tick();
        bus2.Ld_we = 1'b0;
        bus0.Ld_we = 1'b0;
    endtask

    // Presents a single request on the WAIT=2 instance; returns 1 ns after edge 0.
    task automatic issue(input logic [29:0] a);
        bus2.Req  = 1'b1;
        bus2.Addr = a;
        tick();
        bus2.Req  = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({bus2.Ack, bus2.Fault, bus2.Busy} !== 3'b000 || bus2.Instr !== 32'h0)
            $display("FAIL reset_state: ack/fault/busy=%b instr=%h required 000 / 00000000",
                     {bus2.Ack, bus2.Fault, bus2.Busy}, bus2.Instr);
        else passes++;
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) load(10'(i), words[i]);
    endtask

    task automatic test_single();
        issue(30'd1);
        checks++;
        if (bus2.Ack !== 1'b0 || bus2.Busy !== 1'b1)
            $display("FAIL single_c1: ack=%b busy=%b required ack=0 busy=1", bus2.Ack, bus2.Busy);
        else passes++;
        tick();
        checks++;
        if (bus2.Ack !== 1'b0 || bus2.Busy !== 1'b1)
            $display("FAIL single_c2: ack=%b busy=%b required ack=0 busy=1", bus2.Ack, bus2.Busy);
        else passes++;
        tick();
        checks++;
        if (bus2.Ack !== 1'b1 || bus2.Busy !== 1'b0 || bus2.Fault !== 1'b0 || bus2.Instr !== 32'h20090003)
            $display("FAIL single_resp: ack=%b busy=%b fault=%b instr=%h required 1 0 0 20090003",
                     bus2.Ack, bus2.Busy, bus2.Fault, bus2.Instr);
        else passes++;
        tick();
        checks++;
        if (bus2.Ack !== 1'b0 || bus2.Instr !== 32'h20090003)
            $display("FAIL single_hold: ack=%b instr=%h required ack=0 instr=20090003", bus2.Ack, bus2.Instr);
        else passes++;
    endtask

    task automatic test_back_to_back();
        bus2.Req  = 1'b1;
        bus2.Addr = 30'd0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (bus2.Ack !== ((i % 3) == 2))
                $display("FAIL b2b_ack cycle %0d: ack=%b required %b", i, bus2.Ack, ((i % 3) == 2));
            else passes++;
            if ((i % 3) == 2) begin
                checks++;
                if (bus2.Instr !== words[i / 3])
                    $display("FAIL b2b_instr %0d: instr=%h required %h", i / 3, bus2.Instr, words[i / 3]);
                else passes++;
                bus2.Addr = 30'(i / 3 + 1);
            end
        end
        bus2.Req = 1'b0;
        tick();
        checks++;
        if (bus2.Ack !== 1'b0)
            $display("FAIL b2b_end: ack=%b required 0", bus2.Ack);
        else passes++;
    endtask

    task automatic test_wait0();
        bus0.Req  = 1'b1;
        bus0.Addr = 30'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus0.Ack !== 1'b1 || bus0.Instr !== words[i])
                $display("FAIL wait0_fetch %0d: ack=%b instr=%h required 1 %h", i, bus0.Ack, bus0.Instr, words[i]);
            else passes++;
            bus0.Addr = 30'(i + 1);
        end
        bus0.Req = 1'b0;
        tick();
        checks++;
        if (bus0.Ack !== 1'b0)
            $display("FAIL wait0_end: ack=%b required 0", bus0.Ack);
        else passes++;
    endtask

    task automatic test_fault();
        issue(30'h00000400);
        tick();
        tick();
        checks++;
        if (bus2.Ack !== 1'b1 || bus2.Fault !== 1'b1 || bus2.Instr !== 32'h0)
            $display("FAIL fault_set: ack=%b fault=%b instr=%h required 1 1 00000000",
                     bus2.Ack, bus2.Fault, bus2.Instr);
        else passes++;
        tick();
        issue(30'd3);
        tick();
        tick();
        checks++;
        if (bus2.Ack !== 1'b1 || bus2.Fault !== 1'b0 || bus2.Instr !== 32'hAC0A0000)
            $display("FAIL fault_clear: ack=%b fault=%b instr=%h required 1 0 ac0a0000",
                     bus2.Ack, bus2.Fault, bus2.Instr);
        else passes++;
        tick();
    endtask

    task automatic test_loader_collision();
        issue(30'd2);
        tick();
        bus2.Ld_we = 1'b1; bus2.Ld_addr = 10'd2; bus2.Ld_data = 32'hDEADBEEF;
        tick();
        bus2.Ld_we = 1'b0;
        checks++;
        if (bus2.Ack !== 1'b1 || bus2.Instr !== 32'h01095020)
            $display("FAIL ld_read_edge: ack=%b instr=%h required 1 01095020", bus2.Ack, bus2.Instr);
        else passes++;
        tick();
        load(10'd2, 32'h01095020);
        issue(30'd2);
        bus2.Ld_we = 1'b1; bus2.Ld_addr = 10'd2; bus2.Ld_data = 32'hDEADBEEF;
        tick();
        bus2.Ld_we = 1'b0;
        tick();
        checks++;
        if (bus2.Ack !== 1'b1 || bus2.Instr !== 32'hDEADBEEF)
            $display("FAIL ld_wait_edge: ack=%b instr=%h required 1 deadbeef", bus2.Ack, bus2.Instr);
        else passes++;
        tick();
    endtask

    task automatic test_reset_midwait();
        issue(30'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({bus2.Ack, bus2.Fault, bus2.Busy} !== 3'b000 || bus2.Instr !== 32'h0)
            $display("FAIL async_reset: ack/fault/busy=%b instr=%h required 000 / 00000000",
                     {bus2.Ack, bus2.Fault, bus2.Busy}, bus2.Instr);
        else passes++;
        #2;
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus2.Ack !== 1'b0 || bus2.Busy !== 1'b0)
                $display("FAIL dropped_req cycle %0d: ack=%b busy=%b required 0 0", i, bus2.Ack, bus2.Busy);
            else passes++;
        end
        issue(30'd0);
        tick();
        tick();
        checks++;
        if (bus2.Ack !== 1'b1 || bus2.Instr !== 32'h20080005)
            $display("FAIL refetch_after_reset: ack=%b instr=%h required 1 20080005", bus2.Ack, bus2.Instr);
        else passes++;
        tick();
    endtask

    task automatic test_addr_change();
        issue(30'd3);
        bus2.Addr = 30'd0;
        tick();
        tick();
        checks++;
        if (bus2.Ack !== 1'b1 || bus2.Instr !== 32'hAC0A0000)
            $display("FAIL addr_latched: ack=%b instr=%h required 1 ac0a0000", bus2.Ack, bus2.Instr);
        else passes++;
        tick();
    endtask

    initial begin
        checks  = 0;
        passes  = 0;
        Reset_n = 1'b0;
        bus2.Req = 1'b0; bus2.Addr = '0; bus2.Ld_we = 1'b0; bus2.Ld_addr = '0; bus2.Ld_data = '0;
        bus0.Req = 1'b0; bus0.Addr = '0; bus0.Ld_we = 1'b0; bus0.Ld_addr = '0; bus0.Ld_data = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_wait0();
        test_fault();
        test_loader_collision();
        test_reset_midwait();
        test_addr_change();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
